// File: rtl/pe_vreduce.sv
// Frame accumulator and 8-to-1 adder-tree reducer for the vector adder's result stream.
// Handshake: a beat moves on an edge where D_VALID && !D_BP; a result moves on an edge where Q_VALID && !Q_BP.
module pe_vreduce #(
    parameter int W     = 64,
    parameter int LEN_W = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [7:0][W-1:0]   D,
    input  logic                D_VALID,
    output logic                D_BP,
    input  logic [LEN_W-1:0]    LEN,
    output logic [W-1:0]        Q,
    output logic                Q_VALID,
    input  logic                Q_BP
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_TREE,
        S_OUT
    } state_t;

    state_t             state;
    logic [7:0][W-1:0]  acc;
    logic [3:0][W-1:0]  s1;
    logic [1:0][W-1:0]  s2;
    logic [LEN_W-1:0]   cnt;
    logic [LEN_W-1:0]   len_r;
    logic [1:0]         tcnt;
    logic               take;
    logic [LEN_W-1:0]   len_eff;
    logic [LEN_W-1:0]   cnt_nxt;

    // D_BP is registered, so acceptance never depends combinationally on the upstream.
    assign take    = D_VALID && !D_BP;
    assign len_eff = (LEN == '0) ? LEN_W'(1) : LEN;
    assign cnt_nxt = cnt + LEN_W'(1);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= S_IDLE;
            acc     <= '0;
            s1      <= '0;
            s2      <= '0;
            cnt     <= '0;
            len_r   <= '0;
            tcnt    <= '0;
            Q       <= '0;
            Q_VALID <= 1'b0;
            D_BP    <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    D_BP <= 1'b0;
                    if (take) begin
                        len_r <= len_eff;
                        acc   <= D;
                        cnt   <= LEN_W'(1);
                        tcnt  <= '0;
                        if (len_eff == LEN_W'(1)) begin
                            state <= S_TREE;
                            D_BP  <= 1'b1;
                        end else begin
                            state <= S_ACC;
                        end
                    end
                end
                S_ACC: begin
                    if (take) begin
                        for (int i = 0; i < 8; i++) begin
                            acc[i] <= acc[i] + D[i];
                        end
                        cnt  <= cnt_nxt;
                        tcnt <= '0;
                        if (cnt_nxt == len_r) begin
                            state <= S_TREE;
                            D_BP  <= 1'b1;
                        end
                    end
                end
                S_TREE: begin
                    tcnt <= tcnt + 2'd1;
                    case (tcnt)
                        2'd0: begin
                            for (int i = 0; i < 4; i++) begin
                                s1[i] <= acc[2*i] + acc[2*i+1];
                            end
                        end
                        2'd1: begin
                            s2[0] <= s1[0] + s1[1];
                            s2[1] <= s1[2] + s1[3];
                        end
                        default: begin
                            Q       <= s2[0] + s2[1];
                            Q_VALID <= 1'b1;
                            state   <= S_OUT;
                        end
                    endcase
                end
                S_OUT: begin
                    // Q holds until handoff; D_BP releases on the same edge.
                    if (!Q_BP) begin
                        Q_VALID <= 1'b0;
                        D_BP    <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_vreduce.sv
// Self-checking bench for pe_vreduce: directed frames with a scoreboard of expected scalars.
module tb_pe_vreduce;
    localparam int W     = 64;
    localparam int LEN_W = 16;

    logic               CLK = 1'b0;
    logic               RST;
    logic [7:0][W-1:0]  D;
    logic               D_VALID;
    logic               D_BP;
    logic [LEN_W-1:0]   LEN;
    logic [W-1:0]       Q;
    logic               Q_VALID;
    logic               Q_BP;

    int                 n_tests = 0;
    int                 n_fail  = 0;
    logic [W-1:0]       exp_q[$];

    pe_vreduce #(.W(W), .LEN_W(LEN_W)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .D       (D),
        .D_VALID (D_VALID),
        .D_BP    (D_BP),
        .LEN     (LEN),
        .Q       (Q),
        .Q_VALID (Q_VALID),
        .Q_BP    (Q_BP)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // A result is consumed on the edge following a negedge where Q_VALID && !Q_BP.
    always @(negedge CLK) begin
        if (RST === 1'b0 && Q_VALID === 1'b1 && Q_BP === 1'b0) begin
            if (exp_q.size() == 0) check("spurious_result", 64'd1, 64'd0);
            else check("result", Q, exp_q.pop_front());
        end
    end

    task automatic send_beat(input logic [7:0][W-1:0] v, output int waited);
        bit took;
        took    = 1'b0;
        waited  = 0;
        D       = v;
        D_VALID = 1'b1;
        while (!took && waited < 100) begin
            @(negedge CLK);
            took = !D_BP;
            @(posedge CLK);
            #1;
            waited++;
        end
        D_VALID = 1'b0;
        if (!took) check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_frame(input int len_field, input int nbeats, input int gap,
                              input logic [W-1:0] base, input bit ramp, input bit push);
        logic [7:0][W-1:0] v;
        logic [W-1:0]      sum;
        int                w;
        sum = '0;
        for (int l = 0; l < 8; l++) begin
            v[l] = ramp ? base * W'(l + 1) : base;
        end
        for (int b = 0; b < nbeats; b++) begin
            for (int l = 0; l < 8; l++) sum = sum + v[l];
        end
        if (push) exp_q.push_back(sum);
        LEN = LEN_W'(len_field);
        for (int b = 0; b < nbeats; b++) begin
            send_beat(v, w);
            if (b == 0) LEN = LEN_W'($urandom_range(0, 65535));
            if (b != nbeats - 1) repeat (gap) begin
                @(posedge CLK);
                #1;
            end
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(posedge CLK);
            #1;
            k++;
        end
        if (exp_q.size() != 0) check("drain_timeout", W'(exp_q.size()), 64'd0);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [7:0][W-1:0] v;
        int                w;
        int                lat;

        RST     = 1'b1;
        D       = '0;
        D_VALID = 1'b0;
        LEN     = '0;
        Q_BP    = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_q", Q, 64'd0);
        check("rst_q_valid", W'(Q_VALID), 64'd0);
        check("rst_d_bp", W'(D_BP), 64'd1);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        check("d_bp_after_reset", W'(D_BP), 64'd0);

        // One-beat frame, latency and single-cycle Q_VALID.
        send_frame(1, 1, 0, 64'd2, 1'b1, 1'b1);
        check("d_bp_at_accept", W'(D_BP), 64'd1);
        lat = 0;
        while (!Q_VALID && lat < 20) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        check("latency_edges", W'(lat + 1), 64'd4);
        check("d_bp_in_out", W'(D_BP), 64'd1);
        @(posedge CLK);
        #1;
        check("q_valid_one_cycle", W'(Q_VALID), 64'd0);
        check("d_bp_after_handoff", W'(D_BP), 64'd0);

        // Gapped three-beat frame, then a beat held valid through TREE/OUT.
        send_frame(3, 3, 2, 64'd1, 1'b0, 1'b1);
        LEN = LEN_W'(1);
        for (int l = 0; l < 8; l++) v[l] = 64'd9;
        exp_q.push_back(64'd72);
        send_beat(v, w);
        check("next_frame_wait", W'(w), 64'd5);
        drain();

        // Modulo wrap.
        send_frame(2, 2, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
        drain();

        // Downstream stall, then back-to-back frame.
        Q_BP = 1'b1;
        send_frame(1, 1, 0, 64'd1, 1'b1, 1'b1);
        lat = 0;
        while (!Q_VALID && lat < 20) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        repeat (5) begin
            @(posedge CLK);
            #1;
            check("q_hold", Q, 64'd36);
            check("q_valid_hold", W'(Q_VALID), 64'd1);
            check("d_bp_hold", W'(D_BP), 64'd1);
        end
        Q_BP = 1'b0;
        @(posedge CLK);
        #1;
        check("handoff_after_release", W'(Q_VALID), 64'd0);
        send_frame(1, 1, 0, 64'd3, 1'b0, 1'b1);
        drain();

        // LEN of zero behaves as one.
        send_frame(0, 1, 0, 64'd5, 1'b0, 1'b1);
        drain();

        // Reset in the middle of a frame.
        send_frame(4, 2, 0, 64'd7, 1'b0, 1'b0);
        RST = 1'b1;
        repeat (2) begin
            @(posedge CLK);
            #1;
            check("midrst_q", Q, 64'd0);
            check("midrst_q_valid", W'(Q_VALID), 64'd0);
            check("midrst_d_bp", W'(D_BP), 64'd1);
        end
        RST = 1'b0;
        @(posedge CLK);
        #1;
        check("midrst_d_bp_release", W'(D_BP), 64'd0);
        send_frame(1, 1, 0, 64'd1, 1'b1, 1'b1);
        drain();

        check("queue_empty", W'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pe_vreduce.md
# pe_vreduce

Downstream consumer of the vector adder's 8×64-bit result stream (`Q`/`Q_VALID`). It accumulates a frame of `LEN` vectors element-wise, then reduces the 8 lane sums to one 64-bit scalar through a pipelined adder tree. It holds the scalar until the next stage accepts it. It drives backpressure (`D_BP`) to the adder so frames never overlap.

## Interface
- `W`, 64, lane and result width in bits
- `LEN_W`, 16, width of the frame-length input
- `CLK`  in  1  clock; all logic on the rising edge
- `RST`  in  1  reset, synchronous, active-high
- `D`  in  [7:0][W-1:0]  input vector; driven by the adder's `Q`
- `D_VALID`  in  1  `D` carries a beat; driven by the adder's `Q_VALID`
- `D_BP`  out  1  backpressure to upstream; no beat is taken while high
- `LEN`  in  LEN_W  beats per frame; sampled on the first beat of each frame
- `Q`  out  W  reduced scalar result
- `Q_VALID`  out  1  `Q` is valid; held until accepted
- `Q_BP`  in  1  downstream backpressure; while high, the current result is not accepted

## Operation
- Beat accept: a beat is taken at an edge where `D_VALID && !D_BP`. Beats arriving while `D_BP` is high are dropped; upstream must hold them.
- FSM states: IDLE, ACC, TREE, OUT.
- IDLE, on an accepted beat:
  - latch `len_r = (LEN==0) ? 1 : LEN`; `LEN==0` is treated as 1.
  - `acc[i] <= D[i]`, `cnt <= 1`.
  - if `len_r==1`, go to TREE; otherwise go to ACC.
- ACC, on an accepted beat:
  - `acc[i] <= acc[i] + D[i]`, `cnt <= cnt+1`.
  - if `cnt+1 == len_r`, go to TREE.
  - Gaps (`D_VALID` low) are allowed and change nothing.
- TREE takes 3 fixed cycles:
  - stage 1: 4 pairwise sums (lanes 0+1, 2+3, 4+5, 6+7).
  - stage 2: 2 sums.
  - stage 3: 1 sum, written into the `Q` register.
  - then go to OUT.
- OUT:
  - `Q_VALID` is high and `Q` holds steady.
  - at an edge where `Q_BP` is low, the result is handed off: `Q_VALID <= 0`, go to IDLE.
- Arithmetic: all adds are unsigned, modulo 2^W. Overflow wraps silently; there is no carry or saturation output.
- `D_BP` is a registered output:
  - it goes high at the same edge that accepts a frame's last beat;
  - it stays high through TREE and OUT;
  - it goes low at the handoff edge.
  - The first beat of the next frame can therefore be taken one cycle after handoff.
- Reset (`RST` high at an edge), from any state including mid-frame:
  - `Q_VALID=0`, `Q=0`, `D_BP=1`;
  - acc, tree registers and `cnt` are cleared; FSM goes to IDLE;
  - any partial frame is discarded.
  - At the first edge with `RST` low, `D_BP` goes to 0.
- `LEN` changing mid-frame has no effect; only the value sampled on the first beat counts.

## Timing
- Let E be the edge that accepts the last beat of a frame.
  - `D_BP` is 1 after E.
  - Tree stages load at E+1, E+2, E+3.
  - `Q`/`Q_VALID` are visible after E+3.
  - Latency from last beat to result: 4 edges, i.e. 3 cycles of TREE plus the registered output.
- With `Q_BP` low throughout, handoff happens at E+4:
  - `Q_VALID` is high for exactly one cycle;
  - `D_BP` drops after E+4.
- Minimum frame period: `len_r` + 4 cycles.
- `D_BP` never depends combinationally on `D_VALID`, `Q_BP` or `LEN`.
- Reset values: `Q=0`, `Q_VALID=0`, `D_BP=1` while `RST` is high.

## Test plan
- LEN=1, one beat D={2,4,6,8,10,12,14,16} (the adder's output for 1..8 + 1..8) -> Q=72, `Q_VALID` visible 4 edges after accept, high 1 cycle; `D_BP` high from accept through handoff.
- LEN=3, three beats all lanes 1, with 2 idle cycles between beats -> Q=24. `D_VALID` asserted during TREE/OUT is not taken: Q stays 24 and the next frame starts only after handoff.
- Wrap: LEN=2, all lanes 0xFFFF_FFFF_FFFF_FFFF -> Q=0xFFFF_FFFF_FFFF_FFF0.
- Q_BP high for 5 cycles while `Q_VALID`=1 -> Q stable and `D_BP` stays 1. After `Q_BP` drops, handoff occurs on the next edge. A back-to-back second frame (LEN=1, all lanes 3) yields Q=24.
- LEN=0 with one beat all lanes 5 -> treated as LEN=1, Q=40.
- Reset mid-ACC (LEN=4, after 2 beats of all lanes 7) -> `Q_VALID`=0, `Q`=0, `D_BP`=1 during reset. A new frame then (LEN=1, lanes 1..8) -> Q=36, with no residue from the aborted frame.
